// File: rtl/fnd_axil_slave.sv
// AXI4-Lite register slave (CTRL/DATA/DOT/BLANK) driving a 4-digit multiplexed 7-segment display.
// Latency: write ack 1 cycle after AWVALID&&WVALID, RVALID 2 cycles after ARVALID; fnd_font aligned with fnd_com.
// Backpressure: BVALID/RVALID hold until BREADY/RREADY; optional macro FND_LEADING_ZERO_BLANK_EN.
module fnd_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int SCAN_DIV           = 100000
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [3:0]                        fnd_com,
    output logic [7:0]                        fnd_font
);

    localparam int NB = C_S_AXI_DATA_WIDTH / 8;
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t                        w_state_q;
    r_state_t                        r_state_q;
    logic                            awready_q, wready_q, bvalid_q;
    logic                            arready_q, rvalid_q;
    logic [1:0]                      waddr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q, rdata_q;
    logic [NB-1:0]                   wstrb_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   reg_q [4];
    logic [C_S_AXI_DATA_WIDTH-1:0]   reg_d [4];
    logic [PW-1:0]                   presc_q, presc_d;
    logic [1:0]                      idx_q, idx_d;
    logic [3:0]                      fnd_com_q, fnd_com_d;
    logic [7:0]                      fnd_font_q, fnd_font_d;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel: address and data are only taken together
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        waddr_q   <= S_AXI_AWADDR[3:2];
                        wdata_q   <= S_AXI_WDATA;
                        wstrb_q   <= S_AXI_WSTRB;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_ACK;
                    end
                end
                W_ACK: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) reg_d[r] = reg_q[r];
        if (w_state_q == W_ACK) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_q[b]) reg_d[waddr_q][8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        for (int r = 0; r < 4; r++) begin
            if (ARESET) reg_q[r] <= '0;
            else        reg_q[r] <= reg_d[r];
        end
    end

    // Read data is taken from reg_q, so a same-cycle write is not visible
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        arready_q <= 1'b1;
                        r_state_q <= R_ACK;
                    end
                end
                R_ACK: begin
                    arready_q <= 1'b0;
                    rdata_q   <= reg_q[S_AXI_ARADDR[3:2]];
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic       scan_en;
    logic [3:0] cur_nib;
    logic       lz_blank;

    assign scan_en = reg_q[0][0];
    assign cur_nib = reg_q[1][{idx_q, 2'b00} +: 4];

`ifdef FND_LEADING_ZERO_BLANK_EN
    logic [1:0] msd_idx;
    always_comb begin
        msd_idx = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (reg_q[1][4*i +: 4] != 4'd0) msd_idx = 2'(i);
        end
        lz_blank = (idx_q > msd_idx);
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        presc_d    = presc_q;
        idx_d      = idx_q;
        fnd_com_d  = 4'hF;
        fnd_font_d = 8'hFF;
        if (!scan_en) begin
            presc_d = '0;
        end else begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                idx_d   = idx_q + 2'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
            fnd_com_d = ~(4'b0001 << idx_q);
            if (!reg_q[3][idx_q]) begin
                fnd_font_d = {~reg_q[2][idx_q], lz_blank ? 7'h7F : seg7(cur_nib)};
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            presc_q    <= '0;
            idx_q      <= 2'd0;
            fnd_com_q  <= 4'hF;
            fnd_font_q <= 8'hFF;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            fnd_com_q  <= fnd_com_d;
            fnd_font_q <= fnd_font_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign fnd_com       = fnd_com_q;
    assign fnd_font      = fnd_font_q;

endmodule

// File: tb/tb_fnd_axil_slave.sv
// Directed bench for fnd_axil_slave: AXI-Lite register access with a read scoreboard, plus digit scanning.
module tb_fnd_axil_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_font;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model [4];
    logic [31:0] exp_q [$];
    logic [7:0]  font_exp [4];

    fnd_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .SCAN_DIV(4)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .fnd_com(fnd_com), .fnd_font(fnd_font)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int hold_b);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        do begin step(); n++; end while (!awready && n < 20);
        chk("aw_w_ready", {30'd0, awready, wready}, 32'd3);
        chk("aw_wait", n, 1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("ready_pulse", {30'd0, awready, wready}, 32'd0);
        for (int i = 0; i < hold_b; i++) begin
            chk("bvalid_hold", bvalid, 1);
            step();
        end
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, 0);
        step();
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic axi_read(input logic [3:0] a, input int hold_r);
        logic [31:0] first;
        logic [31:0] exp_v;
        int n;
        exp_q.push_back(model[a[3:2]]);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin step(); n++; end while (!rvalid && n < 20);
        arvalid = 1'b0;
        chk("rd_latency", n, 2);
        chk("rvalid", rvalid, 1);
        chk("rresp", rresp, 0);
        first = rdata;
        for (int i = 0; i < hold_r; i++) begin
            step();
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_stable", rdata, first);
        end
        rready = 1'b1;
        exp_v = exp_q.pop_front();
        chk("rdata", rdata, exp_v);
        step();
        rready = 1'b0;
        chk("rvalid_drop", rvalid, 0);
    endtask

    initial begin
        int n;
        logic [3:0] prev;
        logic found;
        for (int r = 0; r < 4; r++) model[r] = '0;
`ifdef FND_LEADING_ZERO_BLANK_EN
        font_exp = '{8'h24, 8'hF9, 8'hFF, 8'hFF};
`else
        font_exp = '{8'h24, 8'hF9, 8'hC0, 8'hC0};
`endif
        rst = 1'b1;
        repeat (3) step();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_resp", {28'd0, bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_com", fnd_com, 32'hF);
        chk("rst_font", fnd_font, 32'hFF);
        rst = 1'b0;
        step();

        // register write/readback
        axi_write(4'h0, 32'd1, 4'hF, 0);
        axi_write(4'h4, 32'd2, 4'hF, 0);
        axi_write(4'h8, 32'd3, 4'hF, 0);
        axi_write(4'hC, 32'd4, 4'hF, 0);
        axi_read(4'h0, 0);
        axi_read(4'h4, 0);
        axi_read(4'h8, 0);
        axi_read(4'hF, 0);

        // lone AWVALID / lone WVALID are never accepted
        awaddr = 4'h4; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("aw_alone", {30'd0, awready, wready}, 0);
        end
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("w_alone", {30'd0, awready, wready}, 0);
        end
        wvalid = 1'b0;
        step();
        chk("w_alone_nobvalid", bvalid, 0);
        axi_read(4'h4, 0);

        // backpressure on B and R
        axi_write(4'h8, 32'hCAFE_0001, 4'hF, 10);
        axi_read(4'h8, 5);

        // byte strobes
        axi_write(4'h4, 32'h0000_0000, 4'hF, 0);
        axi_write(4'h4, 32'h1234_5678, 4'b0010, 0);
        axi_read(4'h4, 0);
        axi_write(4'h5, 32'hAABB_CCDD, 4'b1001, 0);
        axi_read(4'h6, 0);

        // concurrent read and write of the same register returns the old value
        axi_write(4'h8, 32'h0000_0011, 4'hF, 0);
        fork
            axi_write(4'h8, 32'h0000_00A5, 4'hF, 0);
            axi_read(4'h8, 0);
        join
        axi_read(4'h8, 0);

        // scanner
        axi_write(4'h0, 32'd0, 4'hF, 0);
        axi_write(4'h4, 32'h0000_0012, 4'hF, 0);
        axi_write(4'h8, 32'h0000_0001, 4'hF, 0);
        axi_write(4'hC, 32'h0000_0000, 4'hF, 0);
        step();
        chk("dis_com", fnd_com, 32'hF);
        chk("dis_font", fnd_font, 32'hFF);
        axi_write(4'h0, 32'd1, 4'hF, 0);
        prev = fnd_com;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            step();
            n++;
            if (prev == 4'hE && fnd_com == 4'hD) found = 1'b1;
            prev = fnd_com;
        end
        chk("scan_sync", {31'd0, found}, 1);
        for (int k = 0; k < 16; k++) begin
            automatic int dg = (1 + k / 4) % 4;
            chk("scan_com", fnd_com, {28'd0, ~(4'b0001 << dg)});
            chk("scan_font", fnd_font, {24'd0, font_exp[dg]});
            step();
        end

        // BLANK forces digit 0 fully off
        axi_write(4'hC, 32'h0000_0001, 4'hF, 0);
        n = 0;
        while (fnd_com != 4'hE && n < 20) begin step(); n++; end
        chk("blank_com", fnd_com, 32'hE);
        chk("blank_font", fnd_font, 32'hFF);

        axi_write(4'h0, 32'd0, 4'hF, 0);
        step();
        chk("off_com", fnd_com, 32'hF);
        chk("off_font", fnd_font, 32'hFF);

        // reset with a write response outstanding
        axi_write(4'h0, 32'd1, 4'hF, 0);
        awaddr = 4'h4; wdata = 32'h0000_9999; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin step(); n++; end while (!awready && n < 20);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("pre_rst_bvalid", bvalid, 1);
        rst = 1'b1;
        step();
        chk("post_rst_bvalid", bvalid, 0);
        chk("post_rst_com", fnd_com, 32'hF);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) model[r] = '0;
        step();
        chk("post_rst_bvalid2", bvalid, 0);
        axi_read(4'h0, 0);
        axi_read(4'h4, 0);
        axi_read(4'h8, 0);
        axi_read(4'hC, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
